// File: rtl/mod_addsub_seq.sv
// Modular add/subtract sequencer: r = (a +/- b) mod m using one shared external
// adder/subtractor for a raw step and an optional correction step by m.
module mod_addsub_seq #(
    parameter int WIDTH       = 1027,
    parameter int ADD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result
);

    localparam int CW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(ADD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP1,
        S_STEP2,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             step_last;

    assign step_last = (cnt_q == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        m_d          = m_q;
        sub_d        = sub_q;
        t_d          = t_q;
        result_d     = result_q;
        add_start    = 1'b0;
        add_subtract = 1'b0;
        add_a        = '0;
        add_b        = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    sub_d   = subtract;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_STEP1;
                end
            end

            S_STEP1: begin
                add_start    = (cnt_q == CNT_RELOAD);
                add_a        = a_q;
                add_b        = b_q;
                add_subtract = sub_q;
                if (!step_last) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sub_q && !add_result[WIDTH]) begin
                    // No borrow: the difference is already reduced.
                    result_d = add_result[WIDTH-1:0];
                    state_d  = S_DONE;
                end else begin
                    t_d     = add_result[WIDTH-1:0];
                    cnt_d   = CNT_RELOAD;
                    state_d = S_STEP2;
                end
            end

            S_STEP2: begin
                add_start    = (cnt_q == CNT_RELOAD);
                add_a        = t_q;
                add_b        = m_q;
                add_subtract = !sub_q;
                if (!step_last) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Add path keeps the sum when T-m borrows; sub path wraps to a-b+m.
                    if (!sub_q && add_result[WIDTH]) begin
                        result_d = t_q;
                    end else begin
                        result_d = add_result[WIDTH-1:0];
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the wide operand registers are reset too, so every output is a defined 0 after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sub_q    <= 1'b0;
            t_q      <= '0;
            result_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            sub_q    <= sub_d;
            t_q      <= t_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed bench for mod_addsub_seq: two instances (adder latency 1 and 3), each fed by
// a behavioural adder that returns garbage until its operands have been held long enough.
module tb_mod_addsub_seq;

    localparam int W = 1027;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start1 = 1'b0, start3 = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0, b = '0, m = '0;

    logic [W-1:0] result1, add_a1, add_b1, result3, add_a3, add_b3;
    logic         done1, busy1, add_start1, add_sub1;
    logic         done3, busy3, add_start3, add_sub3;
    logic [W:0]   add_res1, add_res3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_addsub_seq #(.WIDTH(W), .ADD_LATENCY(1)) u_l1 (
        .clk(clk), .resetn(resetn), .start(start1), .subtract(sub),
        .in_a(a), .in_b(b), .in_m(m), .result(result1), .done(done1), .busy(busy1),
        .add_start(add_start1), .add_subtract(add_sub1), .add_a(add_a1), .add_b(add_b1),
        .add_result(add_res1)
    );

    mod_addsub_seq #(.WIDTH(W), .ADD_LATENCY(3)) u_l3 (
        .clk(clk), .resetn(resetn), .start(start3), .subtract(sub),
        .in_a(a), .in_b(b), .in_m(m), .result(result3), .done(done3), .busy(busy3),
        .add_start(add_start3), .add_subtract(add_sub3), .add_a(add_a3), .add_b(add_b3),
        .add_result(add_res3)
    );

    // Adder models: cycles elapsed in the current step decide whether the result is ready.
    int el1 = 100, el3 = 100;
    int elapsed1, elapsed3;
    always @(posedge clk) begin
        el1 <= add_start1 ? 1 : ((el1 < 100) ? el1 + 1 : el1);
        el3 <= add_start3 ? 1 : ((el3 < 100) ? el3 + 1 : el3);
    end

    always_comb begin
        elapsed1 = add_start1 ? 0 : el1;
        elapsed3 = add_start3 ? 0 : el3;
        add_res1 = '1;
        add_res3 = '1;
        if (elapsed1 == 0)
            add_res1 = add_sub1 ? ({1'b0, add_a1} - {1'b0, add_b1}) : ({1'b0, add_a1} + {1'b0, add_b1});
        if (elapsed3 == 2)
            add_res3 = add_sub3 ? ({1'b0, add_a3} - {1'b0, add_b3}) : ({1'b0, add_a3} + {1'b0, add_b3});
    end

    // Event monitors sampled on the falling edge, away from register updates.
    int dc1 = 0, dc3 = 0, sc1 = 0, sc3 = 0, unstable3 = 0;
    logic [W-1:0] sa3 = '0, sb3 = '0;
    always @(negedge clk) begin
        if (done1) dc1++;
        if (done3) dc3++;
        if (add_start1) sc1++;
        if (add_start3) begin
            sc3++;
            sa3 = add_a3;
            sb3 = add_b3;
        end else if (busy3 && elapsed3 < 3 && (add_a3 !== sa3 || add_b3 !== sb3)) begin
            unstable3++;
        end
    end

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request on the chosen instance; checks latency, result, add_start count, hold.
    task automatic run_op(input bit use3, input bit sub_v, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] mv,
                          input logic [W-1:0] exp_r, input int exp_lat, input int exp_steps,
                          input string tag);
        int n;
        int s0;
        logic [W-1:0] r;
        @(negedge clk);
        sub = sub_v; a = av; b = bv; m = mv;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        s0 = use3 ? sc3 : sc1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        n = 1;
        while (!(use3 ? done3 : done1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        r = use3 ? result3 : result1;
        check({tag, " latency"}, (W+1)'(n), (W+1)'(exp_lat));
        check({tag, " result"}, {1'b0, r}, {1'b0, exp_r});
        check({tag, " busy@done"}, {{W{1'b0}}, use3 ? busy3 : busy1}, (W+1)'(1));
        @(negedge clk);
        check({tag, " add_start count"}, (W+1)'((use3 ? sc3 : sc1) - s0), (W+1)'(exp_steps));
        @(posedge clk); #1;
        check({tag, " done pulse"}, {{W{1'b0}}, use3 ? done3 : done1}, '0);
        check({tag, " result held"}, {1'b0, use3 ? result3 : result1}, {1'b0, exp_r});
    endtask

    initial begin
        int n;
        int d0;
        logic [W-1:0] big_m;
        big_m = (W'(1) << 1024) - W'(1);

        #2;
        check("reset result", {1'b0, result1}, '0);
        check("reset busy/done", {{(W-1){1'b0}}, busy1, done1}, '0);
        check("reset add_if", {add_a1 | add_b1 | add_a3, add_start1 | add_sub1}, '0);
        @(negedge clk); resetn = 1'b1;

        run_op(0, 0, W'(7),  W'(9),  W'(13), W'(3),  3, 2, "add 7+9 L1");
        run_op(0, 0, W'(3),  W'(4),  W'(13), W'(7),  3, 2, "add 3+4 L1");
        run_op(0, 0, W'(6),  W'(7),  W'(13), W'(0),  3, 2, "add 6+7 L1");
        run_op(0, 0, W'(12), W'(12), W'(13), W'(11), 3, 2, "add 12+12 L1");
        run_op(0, 1, W'(9),  W'(4),  W'(13), W'(5),  2, 1, "sub 9-4 L1");
        run_op(0, 1, W'(4),  W'(9),  W'(13), W'(8),  3, 2, "sub 4-9 L1");
        run_op(0, 1, W'(5),  W'(5),  W'(13), W'(0),  2, 1, "sub 5-5 L1");
        run_op(0, 0, big_m - W'(1), big_m - W'(1), big_m, big_m - W'(2), 3, 2, "add big L1");

        run_op(1, 0, W'(7), W'(9), W'(13), W'(3), 7, 2, "add 7+9 L3");
        run_op(1, 1, W'(4), W'(9), W'(13), W'(8), 7, 2, "sub 4-9 L3");
        run_op(1, 1, W'(9), W'(4), W'(13), W'(5), 4, 1, "sub 9-4 L3");
        check("L3 operand stability", (W+1)'(unstable3), '0);

        // start held high through the whole busy window; only the first is accepted
        @(negedge clk);
        sub = 1'b0; a = W'(7); b = W'(9); m = W'(13); start1 = 1'b1;
        d0 = dc1;
        @(posedge clk); #1;
        a = W'(1); b = W'(1);
        n = 1;
        while (!done1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy-start latency", (W+1)'(n), (W+1)'(3));
        check("busy-start result", {1'b0, result1}, (W+1)'(3));
        @(negedge clk); start1 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy-start done count", (W+1)'(dc1 - d0), (W+1)'(1));
        check("busy-start result kept", {1'b0, result1}, (W+1)'(3));

        // asynchronous reset in the middle of STEP2 on the latency-3 instance
        @(negedge clk);
        sub = 1'b0; a = W'(7); b = W'(9); m = W'(13); start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset in STEP2", {{(W-1){1'b0}}, busy3, add_sub3}, (W+1)'(3));
        d0 = dc3;
        #1; resetn = 1'b0;
        #1;
        check("reset mid result", {1'b0, result3}, '0);
        check("reset mid busy/done", {{(W-1){1'b0}}, busy3, done3}, '0);
        check("reset mid add_if", {add_a3 | add_b3, add_start3 | add_sub3}, '0);
        @(negedge clk); resetn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("no done after reset", (W+1)'(dc3 - d0), '0);
        run_op(1, 0, W'(12), W'(12), W'(13), W'(11), 7, 2, "add 12+12 after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
